// File: rtl/hack_ctrl_unit_if.sv
// Bus bundle for hack_ctrl_unit: instruction handshake,
// ALU drive/return, memory write port, jump and status.
interface hack_ctrl_unit_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] in_m;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        zx;
  logic        nx;
  logic        zy;
  logic        ny;
  logic        f;
  logic        no;
  logic [15:0] alu_out;
  logic [15:0] out_m;
  logic [14:0] addr_m;
  logic        write_m;
  logic        m_ack;
  logic        pc_load;
  logic [14:0] pc_target;
  logic        done;
  logic        illegal;
  logic [15:0] a_reg;
  logic [15:0] d_reg;

  modport master (
    output instr_valid, instr, in_m, alu_out, m_ack,
    input  instr_ready, alu_x, alu_y,
    input  zx, nx, zy, ny, f, no,
    input  out_m, addr_m, write_m,
    input  pc_load, pc_target, done, illegal,
    input  a_reg, d_reg
  );

  modport slave (
    input  instr_valid, instr, in_m, alu_out, m_ack,
    output instr_ready, alu_x, alu_y,
    output zx, nx, zy, ny, f, no,
    output out_m, addr_m, write_m,
    output pc_load, pc_target, done, illegal,
    output a_reg, d_reg
  );
endinterface

// File: rtl/hack_ctrl_unit.sv
// Hack instruction-issue controller: IDLE/EXEC/WB over an external ALU.
// HACK_CTRL_ILLEGAL_TRAP_EN enables trapping C-instrs with ir[14:13]!=11.
module hack_ctrl_unit (
  input logic clk,
  input logic rst_n,
  hack_ctrl_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t state, state_nx;
  logic [15:0] ir, a, d, res;
  logic zr, ng;
  logic jmp, ill_in, ill_ir;
  logic wb_a, wb_c;
  logic ready, wr, dn, pcl, ill;
  logic [5:0] ctl;
  logic [15:0] ax, ay;

`ifdef HACK_CTRL_ILLEGAL_TRAP_EN
  assign ill_in = bus.instr[15] & (bus.instr[14:13] != 2'b11);
  assign ill_ir = ir[15] & (ir[14:13] != 2'b11);
`else
  assign ill_in = 1'b0;
  assign ill_ir = 1'b0;
`endif

  assign jmp = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
      a     <= '0;
      d     <= '0;
      res   <= '0;
      zr    <= 1'b0;
      ng    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.instr_valid)
        ir <= bus.instr;
      if (state == EXEC) begin
        res <= bus.alu_out;
        zr  <= (bus.alu_out == 16'h0);
        ng  <= bus.alu_out[15];
      end
      if (wb_a)
        a <= ir;
      if (wb_c) begin
        if (ir[5]) a <= res;
        if (ir[4]) d <= res;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    wr       = 1'b0;
    dn       = 1'b0;
    pcl      = 1'b0;
    ill      = 1'b0;
    wb_a     = 1'b0;
    wb_c     = 1'b0;
    ctl      = '0;
    ax       = '0;
    ay       = '0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          if (!bus.instr[15] || ill_in)
            state_nx = WB;
          else
            state_nx = EXEC;
        end
      end
      EXEC: begin
        ctl      = ir[11:6];
        ax       = d;
        ay       = ir[12] ? bus.in_m : a;
        state_nx = WB;
      end
      WB: begin
        if (!ir[15]) begin
          dn       = 1'b1;
          wb_a     = 1'b1;
          state_nx = IDLE;
        end else if (ill_ir) begin
          ill      = 1'b1;
          dn       = 1'b1;
          state_nx = IDLE;
        end else begin
          wr = ir[3];
          // M destination retires only on the acknowledge cycle
          if (!ir[3] || bus.m_ack) begin
            dn       = 1'b1;
            pcl      = jmp;
            wb_c     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.instr_ready = ready;
  assign {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ctl;
  assign bus.alu_x     = ax;
  assign bus.alu_y     = ay;
  assign bus.write_m   = wr;
  assign bus.out_m     = wr ? res : 16'h0;
  assign bus.addr_m    = wr ? a[14:0] : 15'h0;
  assign bus.pc_load   = pcl;
  assign bus.pc_target = a[14:0];
  assign bus.done      = dn;
  assign bus.illegal   = ill;
  assign bus.a_reg     = a;
  assign bus.d_reg     = d;
endmodule

// File: tb/tb_hack_ctrl_unit.sv
// Testbench for hack_ctrl_unit: Hack ALU model, vector table,
// retire scoreboard and hand-written reset/handshake sequences.
module tb_hack_ctrl_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  hack_ctrl_unit_if bus ();

  hack_ctrl_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference Hack ALU
  logic [15:0] mx, my, mo;
  always_comb begin
    mx = bus.zx ? 16'h0 : bus.alu_x;
    mx = bus.nx ? ~mx : mx;
    my = bus.zy ? 16'h0 : bus.alu_y;
    my = bus.ny ? ~my : my;
    mo = bus.f ? (mx + my) : (mx & my);
    bus.alu_out = bus.no ? ~mo : mo;
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] in_m;
    int          ackw;
    bit          eexec;
    logic [5:0]  ectl;
    logic [15:0] ex;
    logic [15:0] ey;
    bit          ewr;
    logic [15:0] eout;
    logic [14:0] eaddr;
    bit          epc;
    logic [14:0] etgt;
    bit          eill;
    logic [15:0] ea;
    logic [15:0] ed;
  } vec_t;

  vec_t tv[13];
  vec_t sb[$];

  function automatic vec_t mk(
    logic [15:0] i, logic [15:0] m, int w,
    bit x, logic [5:0] c, logic [15:0] ex, logic [15:0] ey,
    bit wr, logic [15:0] o, logic [14:0] ad,
    bit pc, logic [14:0] tg, bit il,
    logic [15:0] ea, logic [15:0] ed);
    vec_t v;
    v.instr = i; v.in_m = m; v.ackw = w;
    v.eexec = x; v.ectl = c; v.ex = ex; v.ey = ey;
    v.ewr = wr; v.eout = o; v.eaddr = ad;
    v.epc = pc; v.etgt = tg; v.eill = il;
    v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    vec_t e;
    int waits, lat;
    bit got, saw_wr;
    lat = (!v.instr[15] || v.eill) ? 0 : 1 + v.ackw;
    chk($sformatf("ready[%0d]", k), bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr = v.instr;
    bus.in_m = v.in_m;
    sb.push_back(v);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    waits = 0;
    got = 0;
    saw_wr = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      if (c == 0 && v.eexec) begin
        chk($sformatf("ctl[%0d]", k),
            {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}, v.ectl);
        chk($sformatf("alu_x[%0d]", k), bus.alu_x, v.ex);
        chk($sformatf("alu_y[%0d]", k), bus.alu_y, v.ey);
      end
      if (bus.write_m) begin
        if (!saw_wr) begin
          chk($sformatf("out_m[%0d]", k), bus.out_m, v.eout);
          chk($sformatf("addr_m[%0d]", k), bus.addr_m, v.eaddr);
        end
        saw_wr = 1;
        if (waits == v.ackw) bus.m_ack = 1'b1;
        else waits++;
        #1;
      end
      if (bus.done) begin
        e = sb.pop_front();
        got = 1;
        chk($sformatf("lat[%0d]", k), c, lat);
        chk($sformatf("pc_load[%0d]", k), bus.pc_load, e.epc);
        if (e.epc)
          chk($sformatf("pc_tgt[%0d]", k), bus.pc_target, e.etgt);
        chk($sformatf("illegal[%0d]", k), bus.illegal, e.eill);
        chk($sformatf("wr_seen[%0d]", k), saw_wr, e.ewr);
        chk($sformatf("x_idle[%0d]", k), bus.alu_x, 0);
      end
      @(posedge clk); #1;
      bus.m_ack = 1'b0;
      if (got) begin
        chk($sformatf("a_reg[%0d]", k), bus.a_reg, e.ea);
        chk($sformatf("d_reg[%0d]", k), bus.d_reg, e.ed);
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL timeout[%0d]: got no done want done", k);
      sb.delete();
    end
  endtask

  logic [15:0] dv;

  initial begin
`ifdef HACK_CTRL_ILLEGAL_TRAP_EN
    dv = 16'h1234;
`else
    dv = 16'h00FF;
`endif
    tv[0]  = mk(16'h00FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00FF, 16'h0000);
    tv[1]  = mk(16'hEC10, 0, 0, 1, 6'b110000, 16'h0000, 16'h00FF,
                0, 0, 0, 0, 0, 0, 16'h00FF, 16'h00FF);
    tv[2]  = mk(16'h003F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h003F, 16'h00FF);
    tv[3]  = mk(16'hE4C8, 0, 3, 1, 6'b010011, 16'h00FF, 16'h003F,
                1, 16'h00C0, 15'h003F, 0, 0, 0, 16'h003F, 16'h00FF);
    tv[4]  = mk(16'h0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0010, 16'h00FF);
    tv[5]  = mk(16'hE302, 0, 0, 1, 6'b001100, 16'h00FF, 16'h0010,
                0, 0, 0, 0, 0, 0, 16'h0010, 16'h00FF);
    tv[6]  = mk(16'hEA90, 0, 0, 1, 6'b101010, 16'h00FF, 16'h0010,
                0, 0, 0, 0, 0, 0, 16'h0010, 16'h0000);
    tv[7]  = mk(16'hE302, 0, 0, 1, 6'b001100, 16'h0000, 16'h0010,
                0, 0, 0, 1, 15'h0010, 0, 16'h0010, 16'h0000);
    tv[8]  = mk(16'hE308, 0, 0, 1, 6'b001100, 16'h0000, 16'h0010,
                1, 16'h0000, 15'h0010, 0, 0, 0, 16'h0010, 16'h0000);
    tv[9]  = mk(16'hFC10, 16'h1234, 0, 1, 6'b110000, 16'h0000, 16'h1234,
                0, 0, 0, 0, 0, 0, 16'h0010, 16'h1234);
    tv[10] = mk(16'h00FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00FF, 16'h1234);
`ifdef HACK_CTRL_ILLEGAL_TRAP_EN
    tv[11] = mk(16'h8C10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h00FF, 16'h1234);
`else
    tv[11] = mk(16'h8C10, 0, 0, 1, 6'b110000, 16'h1234, 16'h00FF,
                0, 0, 0, 0, 0, 0, 16'h00FF, 16'h00FF);
`endif
    tv[12] = mk(16'hE7EF, 0, 1, 1, 6'b011111, dv, 16'h00FF,
                1, dv + 16'h1, 15'h00FF, 1, 15'h00FF, 0, dv + 16'h1, dv);

    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    bus.in_m = 16'h0;
    bus.m_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_outs", {bus.write_m, bus.done, bus.pc_load, bus.illegal,
                     bus.out_m, bus.addr_m}, 0);
    chk("rst_regs", {bus.a_reg, bus.d_reg}, 0);
    rst_n = 1'b1;
    // ack outside WB must be ignored
    bus.m_ack = 1'b1;
    @(posedge clk); #1;
    bus.m_ack = 1'b0;
    chk("ack_idle", {bus.done, bus.write_m, bus.instr_ready}, 3'b001);

    for (int k = 0; k < 13; k++)
      run_vec(k, tv[k]);

    // valid held while busy is not accepted
    bus.instr_valid = 1'b1;
    bus.instr = 16'h0005;
    @(posedge clk); #1;
    bus.instr = 16'h0077;
    chk("busy_ready", bus.instr_ready, 0);
    chk("busy_done", bus.done, 1);
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_a", bus.a_reg, 16'h0005);
    @(posedge clk); #1;
    chk("busy_a2", bus.a_reg, 16'h0005);

    // reset while an M write waits for ack
    bus.instr_valid = 1'b1;
    bus.instr = 16'hE308;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_wr", bus.write_m, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_wr_off", bus.write_m, 0);
    chk("mid_regs", {bus.a_reg, bus.d_reg}, 0);
    chk("mid_ready", bus.instr_ready, 1);
    chk("mid_done", bus.done, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_done", bus.done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hack_ctrl_unit.md
# hack_ctrl_unit

Instruction-issue controller that drives the 16-bit Hack-style ALU from the instruction side. It accepts 16-bit Hack instruction words over a valid/ready handshake and owns the A and D registers. For each instruction it generates the six ALU control bits (zx, nx, zy, ny, f, no) and operands, captures the ALU result and flags, then performs register, memory and jump writeback. It sits between instruction fetch and the combinational ALU, with a simple acknowledged data-memory write port.

## Interface
- No parameters; datapath fixed at 16 bits, addresses 15 bits.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  unit can accept; high only in IDLE
- instr  in  16  Hack word; bit15=0 A-instr, bit15=1 C-instr
- in_m  in  16  memory read data M, sampled in EXEC
- alu_x  out  16  ALU X operand
- alu_y  out  16  ALU Y operand
- zx, nx, zy, ny, f, no  out  1 each  ALU controls
- alu_out  in  16  ALU OUT, sampled in EXEC
- out_m  out  16  memory write data
- addr_m  out  15  memory write address
- write_m  out  1  memory write request, held until m_ack
- m_ack  in  1  memory write accepted
- pc_load  out  1  one-cycle jump pulse
- pc_target  out  15  jump target
- done  out  1  one-cycle retire pulse
- illegal  out  1  one-cycle trap pulse; tied 0 without macro
- a_reg, d_reg  out  16 each  current A and D (debug)

## Operation
- States: IDLE, EXEC, WB.
- IDLE: instr_ready=1; on instr_valid&&instr_ready latch instr into ir. A-instr -> WB; C-instr -> EXEC.
- EXEC (C-instr only, one cycle):
  - {zx,nx,zy,ny,f,no} = ir[11:6].
  - alu_x = D; alu_y = ir[12] ? in_m : A.
  - Register res = alu_out, zr = (alu_out==0), ng = alu_out[15].
  - jmp = (ir[2]&ng) | (ir[1]&zr) | (ir[0]&~ng&~zr).
  - -> WB.
- Outside EXEC: ALU controls, alu_x and alu_y are all 0.
- WB, A-instr: A <= ir; done=1; -> IDLE.
- WB, C-instr without ir[3]: in the same cycle, set done=1 and pc_load=jmp; apply A <= res if ir[5] and D <= res if ir[4]; -> IDLE.
- WB, C-instr with ir[3] (M dest):
  - write_m=1, out_m=res, addr_m=A[14:0], using the pre-update A.
  - Stay in WB until m_ack=1.
  - On the ack cycle: A/D updates, done, pc_load=jmp; -> IDLE.
- pc_target = A[14:0] as held entering WB, i.e. pre-update A.
- out_m and addr_m are 0 when write_m=0.
- Arithmetic is modulo 2^16 and handled entirely by the ALU; the unit does no arithmetic.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, A=D=ir=res=0, jmp=zr=ng=0. All outputs 0 except instr_ready=1.
- Reset in EXEC or WB aborts the instruction: no A/D update, no done. A pending write_m drops the next cycle.
- Handshake at edge 0:
  - A-instr: done at cycle 1; instr_ready at cycle 2.
  - C-instr: EXEC at cycle 1; done at cycle 2; instr_ready at cycle 3.
  - M write: done is delayed by the m_ack wait.
- m_ack already high on the first WB cycle: zero-wait, retires that cycle.
- m_ack outside WB is ignored.
- instr_valid while instr_ready=0 is ignored. The instr word need not be held after the handshake.
- done, pc_load and illegal are single-cycle pulses.

## Configuration
- HACK_CTRL_ILLEGAL_TRAP_EN defined: a C-instr with ir[14:13]!=2'b11 goes IDLE->WB directly, skipping EXEC. In WB it pulses illegal=1 and done=1 with no A/D/M write and no pc_load.
- HACK_CTRL_ILLEGAL_TRAP_EN undefined: ir[14:13] is ignored, and illegal is constant 0.

## Test plan
- Reset then A-instr 0x00FF: a_reg=0x00FF and done one cycle after handshake; write_m never asserted.
- D=A, instr 0xEC10 with A=0x00FF: EXEC shows zx=1,nx=1,zy=0,ny=0,f=0,no=0, alu_x=0, alu_y=0x00FF. After WB, d_reg=0x00FF and a_reg unchanged.
- M=D-A: load A=0x003F (D=0x00FF), then 0xE4C8:
  - write_m=1 with out_m=0x00C0 and addr_m=0x003F.
  - Hold m_ack=0 for 3 cycles: write_m stays 1, instr_ready=0, no done.
  - Assert m_ack: done that cycle, IDLE next.
- D;JEQ 0xE302 with A=0x0010:
  - D=0: pc_load=1, pc_target=0x0010.
  - D=0x00FF: pc_load stays 0, done still pulses.
- Reset mid-WB: drop rst_n while write_m=1 on an M-write instruction. Next cycle write_m=0, a_reg=d_reg=0, instr_ready=1, and done never pulses.
- 0x8C10 with D=0x1234, A=0x00FF:
  - Macro defined: illegal=1, done=1, d_reg stays 0x1234.
  - Macro undefined: d_reg becomes 0x00FF, illegal=0.
